shift_exec: RTL and testbench

SHIFT_EXEC -- requirements
Module: shift_exec

---
 rtl/shift_exec.sv | 79 +++++++
 tb/tb_shift_exec.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/shift_exec.sv
// Iterative one-bit-per-cycle shifter (SLL / SRL / SRA) driven by an IDLE/SHIFT/DONE FSM.
// A request is captured only in IDLE; the result is published with a one-cycle shift_valid pulse.
module shift_exec #(
  parameter int DATA_W = 32
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              enable_shift,
  input  logic [4:0]        shift_number,
  input  logic [1:0]        shift_op,
  input  logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] shift_out,
  output logic              shift_valid,
  output logic              shift_busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t            state;
  logic [DATA_W-1:0] work;
  logic [4:0]        cnt;
  logic [1:0]        op;

  // Single-bit step; the reserved op never reaches SHIFT, so it simply passes through.
  function automatic logic [DATA_W-1:0] shift_one(input logic [DATA_W-1:0] v,
                                                  input logic [1:0]        o);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    case (o)
      OP_SLL:  shift_one = {v[DATA_W-2:0], 1'b0};
      OP_SRL:  shift_one = {1'b0, v[DATA_W-1:1]};
      OP_SRA:  shift_one = sv >>> 1;
      default: shift_one = v;
    endcase
  endfunction

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      work        <= '0;
      cnt         <= '0;
      op          <= OP_SLL;
      shift_out   <= '0;
      shift_valid <= 1'b0;
    end else begin
      shift_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_shift) begin
            work  <= src1;
            op    <= shift_op;
            cnt   <= shift_number;
            state <= (shift_number == 5'd0 || shift_op == OP_RSV) ? DONE : SHIFT;
          end
        end
        SHIFT: begin
          work <= shift_one(work, op);
          cnt  <= cnt - 5'd1;
          if (cnt == 5'd1)
            state <= DONE;
        end
        DONE: begin
          shift_out   <= work;
          shift_valid <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign shift_busy = (state != IDLE);

endmodule

// File: tb/tb_shift_exec.sv
// Directed testbench for shift_exec: hand-computed results, latencies, busy width,
// busy-time request dropping, back-to-back capture and asynchronous reset behaviour.
module tb_shift_exec;

  logic        CLOCK;
  logic        RESET;
  logic        enable_shift;
  logic [4:0]  shift_number;
  logic [1:0]  shift_op;
  logic [31:0] src1;
  logic [31:0] shift_out;
  logic        shift_valid;
  logic        shift_busy;

  int n_checks = 0;
  int n_errors = 0;

  shift_exec #(.DATA_W(32)) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .enable_shift (enable_shift),
    .shift_number (shift_number),
    .shift_op     (shift_op),
    .src1         (src1),
    .shift_out    (shift_out),
    .shift_valid  (shift_valid),
    .shift_busy   (shift_busy)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present a request at the current sample point and let the next edge capture it.
  task automatic issue(input logic [31:0] s, input logic [4:0] n, input logic [1:0] o,
                       input string tag);
    src1         = s;
    shift_number = n;
    shift_op     = o;
    enable_shift = 1'b1;
    @(posedge CLOCK); #1;
    enable_shift = 1'b0;
    chk({tag, "_busy_after_capture"}, 32'(shift_busy), 32'd1);
  endtask

  // Count edges after the capture edge until shift_valid, bounded.
  task automatic wait_valid(input int lat, input logic [31:0] exp, input string tag);
    int k;
    int busy_n;
    bit got;
    k = 0; busy_n = 0; got = 1'b0;
    while (!got && k < 64) begin
      @(posedge CLOCK); #1;
      k++;
      if (shift_valid) got = 1'b1;
      else if (shift_busy) busy_n++;
    end
    chk({tag, "_latency"}, 32'(k), 32'(lat));
    chk({tag, "_out"}, shift_out, exp);
    chk({tag, "_busy_cycles"}, 32'(busy_n + 1), 32'(lat));
    chk({tag, "_idle_at_valid"}, 32'(shift_busy), 32'd0);
  endtask

  task automatic pulse_end(input logic [31:0] exp, input string tag);
    @(posedge CLOCK); #1;
    chk({tag, "_valid_one_cycle"}, 32'(shift_valid), 32'd0);
    chk({tag, "_out_hold"}, shift_out, exp);
  endtask

  initial begin
    int vcount;
    RESET        = 1'b1;
    enable_shift = 1'b0;
    shift_number = 5'd0;
    shift_op     = 2'b00;
    src1         = 32'h0;
    #2;
    chk("reset_out", shift_out, 32'h0);
    chk("reset_valid", 32'(shift_valid), 32'd0);
    chk("reset_busy", 32'(shift_busy), 32'd0);
    // A request held during reset must not start anything.
    enable_shift = 1'b1;
    src1         = 32'h1234_5678;
    repeat (2) @(posedge CLOCK);
    #1;
    chk("reset_hold_busy", 32'(shift_busy), 32'd0);
    chk("reset_hold_out", shift_out, 32'h0);
    enable_shift = 1'b0;
    #2 RESET = 1'b0;
    @(posedge CLOCK); #1;

    issue(32'h0000_0001, 5'd4, 2'b00, "sll4");
    wait_valid(5, 32'h0000_0010, "sll4");
    pulse_end(32'h0000_0010, "sll4");

    issue(32'hF000_0000, 5'd31, 2'b10, "sra31");
    wait_valid(32, 32'hFFFF_FFFF, "sra31");

    issue(32'hF000_0000, 5'd31, 2'b01, "srl31");
    wait_valid(32, 32'h0000_0001, "srl31");

    issue(32'h0000_0001, 5'd31, 2'b00, "sll31");
    wait_valid(32, 32'h8000_0000, "sll31");

    issue(32'h8000_0000, 5'd31, 2'b10, "sra31b");
    wait_valid(32, 32'hFFFF_FFFF, "sra31b");

    issue(32'hDEAD_BEEF, 5'd0, 2'b01, "srl0");
    wait_valid(1, 32'hDEAD_BEEF, "srl0");
    pulse_end(32'hDEAD_BEEF, "srl0");

    issue(32'h0000_0000, 5'd0, 2'b00, "clr");
    wait_valid(1, 32'h0000_0000, "clr");

    issue(32'hDEAD_BEEF, 5'd7, 2'b11, "rsv7");
    wait_valid(1, 32'hDEAD_BEEF, "rsv7");

    issue(32'h8000_0010, 5'd4, 2'b10, "sra4");
    wait_valid(5, 32'hF800_0001, "sra4");

    issue(32'h8000_0000, 5'd1, 2'b01, "srl1");
    wait_valid(2, 32'h4000_0000, "srl1");

    // Held request while busy is ignored, then captured in the valid cycle.
    issue(32'h0000_0001, 5'd3, 2'b00, "busyA");
    src1         = 32'h1234_5678;
    shift_number = 5'd2;
    shift_op     = 2'b01;
    enable_shift = 1'b1;
    wait_valid(4, 32'h0000_0008, "busyA");
    @(posedge CLOCK); #1;
    enable_shift = 1'b0;
    chk("b2b_busy_after_capture", 32'(shift_busy), 32'd1);
    wait_valid(3, 32'h048D_159E, "b2b");
    pulse_end(32'h048D_159E, "b2b");

    // Asynchronous abort two cycles into a long operation.
    issue(32'h0000_0001, 5'd10, 2'b00, "abort");
    @(posedge CLOCK); #1;
    #3 RESET = 1'b1;
    #1;
    chk("abort_out_async", shift_out, 32'h0);
    chk("abort_valid_async", 32'(shift_valid), 32'd0);
    chk("abort_busy_async", 32'(shift_busy), 32'd0);
    enable_shift = 1'b1;
    src1         = 32'hFFFF_FFFF;
    shift_number = 5'd3;
    repeat (2) @(posedge CLOCK);
    #1;
    chk("abort_hold_out", shift_out, 32'h0);
    chk("abort_hold_busy", 32'(shift_busy), 32'd0);
    enable_shift = 1'b0;
    #2 RESET = 1'b0;
    vcount = 0;
    repeat (14) begin
      @(posedge CLOCK); #1;
      if (shift_valid) vcount++;
    end
    chk("abort_no_valid", 32'(vcount), 32'd0);
    chk("abort_idle", 32'(shift_busy), 32'd0);

    issue(32'hA5A5_A5A5, 5'd1, 2'b00, "post_reset");
    wait_valid(2, 32'h4B4B_4B4A, "post_reset");
    pulse_end(32'h4B4B_4B4A, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
